mem_bus_ctrl: RTL and testbench

Parametrised memory controller between the shared-databus multi-cycle RV datapath and on-chip data RAM, replacing the fixed word-only RAM hookup. It accepts one load/store request at a time through a valid/ready handshake. It supports byte, half and word accesses with sign or zero extension, and flags misaligned or out-of-range accesses. It optionally exposes a memory-mapped LED output register.

---
 rtl/mem_bus_pkg.sv | 54 +++++
 rtl/mem_bus_if.sv | 25 ++
 rtl/mem_bus_ram.sv | 25 ++
 rtl/mem_bus_ctrl.sv | 144 ++++++++++++++
 tb/tb_mem_bus_ctrl.sv | 389 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_bus_pkg.sv
// rtl/mem_bus_pkg.sv - shared types and byte-lane helpers for the data-memory controller
package mem_bus_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2,
    SZ_ILL  = 2'd3
  } size_e;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_e;

  function automatic logic [3:0] byte_en(size_e sz, logic [1:0] lo);
    case (sz)
      SZ_BYTE: byte_en = 4'b0001 << lo;
      SZ_HALF: byte_en = 4'b0011 << lo;
      default: byte_en = 4'b1111;
    endcase
  endfunction

  function automatic logic size_err(size_e sz, logic [1:0] lo);
    case (sz)
      SZ_BYTE: size_err = 1'b0;
      SZ_HALF: size_err = lo[0];
      SZ_WORD: size_err = (lo != 2'b00);
      default: size_err = 1'b1;
    endcase
  endfunction

  // Store data arrives right-aligned; copying it into every lane lets the
  // byte enables alone pick the destination.
  function automatic logic [31:0] replicate(logic [31:0] w, size_e sz);
    case (sz)
      SZ_BYTE: replicate = {4{w[7:0]}};
      SZ_HALF: replicate = {2{w[15:0]}};
      default: replicate = w;
    endcase
  endfunction

  function automatic logic [31:0] lane_extract(logic [31:0] w, logic [1:0] lo, size_e sz, logic uns);
    logic [31:0] s;
    s = w >> {lo, 3'b000};
    case (sz)
      SZ_BYTE: lane_extract = {{24{~uns & s[7]}}, s[7:0]};
      SZ_HALF: lane_extract = {{16{~uns & s[15]}}, s[15:0]};
      default: lane_extract = s;
    endcase
  endfunction

endpackage

// File: rtl/mem_bus_if.sv
// rtl/mem_bus_if.sv - request/response bus between the datapath and the memory controller
interface mem_bus_if #(
  parameter int DATA_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [DATA_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/mem_bus_ram.sv
// rtl/mem_bus_ram.sv - single-port synchronous RAM with byte write enables and registered read
module mem_bus_ram #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1024,
  localparam int AW    = $clog2(DEPTH),
  localparam int NB    = DATA_W / 8
) (
  input  logic              clk,
  input  logic              en_i,
  input  logic [NB-1:0]     be_i,
  input  logic [AW-1:0]     addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);
  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (en_i) begin
      for (int b = 0; b < NB; b++) begin
        if (be_i[b]) mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
      rdata_o <= mem_q[addr_i];
    end
  end
endmodule

// File: rtl/mem_bus_ctrl.sv
// rtl/mem_bus_ctrl.sv - one-at-a-time load/store controller for the datapath's data RAM
// Define MEM_MMIO_EN to map the LED register at MMIO_BASE.
module mem_bus_ctrl
  import mem_bus_pkg::*;
#(
  parameter int                DATA_W    = 32,
  parameter int                DEPTH     = 1024,
  parameter int                LED_W     = 16,
  parameter logic [DATA_W-1:0] MMIO_BASE = 32'h0000_1000
) (
  input  logic             clk,
  input  logic             rst,
  mem_bus_if.slave         bus,
  output logic [LED_W-1:0] led
);
  localparam int AW = $clog2(DEPTH);
`ifdef MEM_MMIO_EN
  localparam logic MMIO_EN = 1'b1;
`else
  localparam logic MMIO_EN = 1'b0;
`endif

  state_e            st_q;
  size_e             size_q;
  logic              we_q;
  logic              uns_q;
  logic              mmio_q;
  logic [DATA_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              rsp_valid_q;
  logic              rsp_err_q;
  logic [DATA_W-1:0] rsp_rdata_q;

  logic              ram_hit;
  logic              mmio_hit;
  logic              err;
  logic              ram_en;
  logic [3:0]        wr_be;
  logic [DATA_W-1:0] wdata_rep;
  logic [DATA_W-1:0] ram_rdata;
  logic [DATA_W-1:0] rd_word;
  logic [DATA_W-1:0] led_word;

  assign ram_hit   = (addr_q >> (AW + 2)) == '0;
  assign mmio_hit  = MMIO_EN && (addr_q[DATA_W-1:2] == MMIO_BASE[DATA_W-1:2]);
  assign err       = size_err(size_q, addr_q[1:0]) || !(ram_hit || mmio_hit);
  assign wr_be     = byte_en(size_q, addr_q[1:0]);
  assign wdata_rep = replicate(wdata_q, size_q);
  assign ram_en    = (st_q == ACCESS) && !err && !mmio_hit;
  assign rd_word   = mmio_q ? led_word : ram_rdata;

  mem_bus_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk     (clk),
    .en_i    (ram_en),
    .be_i    (we_q ? wr_be : 4'b0000),
    .addr_i  (addr_q[AW+1:2]),
    .wdata_i (wdata_rep),
    .rdata_o (ram_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q        <= IDLE;
      size_q      <= SZ_BYTE;
      we_q        <= 1'b0;
      uns_q       <= 1'b0;
      mmio_q      <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      case (st_q)
        IDLE: begin
          if (bus.req_valid) begin
            size_q  <= size_e'(bus.req_size);
            we_q    <= bus.req_we;
            uns_q   <= bus.req_unsigned;
            addr_q  <= bus.req_addr;
            wdata_q <= bus.req_wdata;
            st_q    <= ACCESS;
          end
        end
        ACCESS: begin
          mmio_q <= mmio_hit;
          if (err) begin
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b1;
            st_q        <= IDLE;
          end else if (we_q) begin
            rsp_valid_q <= 1'b1;
            st_q        <= IDLE;
          end else begin
            st_q <= RESP;
          end
        end
        RESP: begin
          rsp_valid_q <= 1'b1;
          rsp_rdata_q <= lane_extract(rd_word, addr_q[1:0], size_q, uns_q);
          st_q        <= IDLE;
        end
        default: st_q <= IDLE;
      endcase
    end
  end

`ifdef MEM_MMIO_EN
  logic [LED_W-1:0] led_q;
  logic [LED_W-1:0] led_d;

  always_comb begin
    led_d = led_q;
    for (int i = 0; i < LED_W; i++) begin
      if (wr_be[i/8]) led_d[i] = wdata_rep[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      led_q <= '0;
    end else if (st_q == ACCESS && we_q && !err && mmio_hit) begin
      led_q <= led_d;
    end
  end

  assign led_word = DATA_W'(led_q);
  assign led      = led_q;
`else
  assign led_word = '0;
  assign led      = '0;
`endif

  assign bus.req_ready = (st_q == IDLE);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_rdata = rsp_rdata_q;
endmodule

// File: tb/tb_mem_bus_ctrl.sv
// tb/tb_mem_bus_ctrl.sv - self-checking bench for mem_bus_ctrl against a byte-addressed memory model
module tb_mem_bus_ctrl;
  localparam int          DATA_W    = 32;
  localparam int          DEPTH     = 1024;
  localparam int          LED_W     = 16;
  localparam logic [31:0] MMIO_BASE = 32'h0000_1000;
`ifdef MEM_MMIO_EN
  localparam bit MMIO_ON = 1'b1;
`else
  localparam bit MMIO_ON = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [LED_W-1:0] led;

  mem_bus_if #(.DATA_W(DATA_W)) bus ();

  mem_bus_ctrl #(
    .DATA_W    (DATA_W),
    .DEPTH     (DEPTH),
    .LED_W     (LED_W),
    .MMIO_BASE (MMIO_BASE)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus),
    .led (led)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [7:0] mem_m [DEPTH*4];
  logic [7:0] led_m [LED_W/8];

  task automatic model(input logic we, input logic [1:0] sz, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wd,
                       output logic err, output logic [31:0] rd, output int lat);
    int         n;
    int         off;
    bit         mmio;
    logic [7:0] b;
    logic [31:0] v;
    n    = 1 << sz;
    mmio = MMIO_ON && (addr >= MMIO_BASE) && (addr - MMIO_BASE < 4);
    err  = (sz == 2'd3) || (addr % n != 0) || !((addr < DEPTH*4) || mmio);
    rd   = '0;
    lat  = 1;
    if (err) return;
    off = mmio ? int'(addr - MMIO_BASE) : int'(addr);
    if (we) begin
      for (int i = 0; i < n; i++) begin
        if (!mmio) mem_m[off+i] = wd[8*i +: 8];
        else if (off + i < LED_W/8) led_m[off+i] = wd[8*i +: 8];
      end
    end else begin
      lat = 2;
      v   = '0;
      for (int i = 0; i < n; i++) begin
        b = !mmio ? mem_m[off+i] : ((off + i < LED_W/8) ? led_m[off+i] : 8'h00);
        v = v | (32'(b) << (8*i));
      end
      if (!uns && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
      rd = v;
    end
  endtask

  function automatic logic [LED_W-1:0] led_exp();
    logic [LED_W-1:0] v;
    for (int i = 0; i < LED_W/8; i++) v[8*i +: 8] = led_m[i];
    return v;
  endfunction

  // Called at a negedge with the DUT idle; lat stays 0 if no response arrives.
  task automatic do_req(input logic we, input logic [1:0] sz, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wd,
                        output logic err, output logic [31:0] rd, output int lat);
    bus.req_valid    = 1'b1;
    bus.req_we       = we;
    bus.req_size     = sz;
    bus.req_unsigned = uns;
    bus.req_addr     = addr;
    bus.req_wdata    = wd;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    err = 1'b0;
    rd  = '0;
    lat = 0;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.rsp_valid) begin
        err = bus.rsp_err;
        rd  = bus.rsp_rdata;
        lat = k;
        break;
      end
    end
  endtask

  task automatic issue(input logic we, input logic [1:0] sz, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wd,
                       output logic err, output logic [31:0] rd, output int lat);
    logic        me;
    logic [31:0] mr;
    int          ml;
    model(we, sz, uns, addr, wd, me, mr, ml);
    do_req(we, sz, uns, addr, wd, err, rd, lat);
  endtask

  task automatic test_reset();
    bus.req_valid    = 1'b0;
    bus.req_we       = 1'b0;
    bus.req_size     = 2'd0;
    bus.req_unsigned = 1'b0;
    bus.req_addr     = '0;
    bus.req_wdata    = '0;
    for (int i = 0; i < LED_W/8; i++) led_m[i] = 8'h00;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0 || bus.rsp_err !== 1'b0 ||
        bus.rsp_rdata !== 32'h0 || led !== '0) begin
      failures++;
      $display("FAIL reset ready=%0b valid=%0b err=%0b rdata=%h led=%h, want 1 0 0 00000000 0000",
               bus.req_ready, bus.rsp_valid, bus.rsp_err, bus.rsp_rdata, led);
    end
  endtask

  task automatic test_init();
    logic e; logic [31:0] r; int l;
    for (int w = 0; w < 64; w++) begin
      issue(1'b1, 2'd2, 1'b0, 32'(w*4), $urandom, e, r, l);
      checks++;
      if (e !== 1'b0 || l !== 1) begin
        failures++;
        $display("FAIL init_store w=%0d err=%0b lat=%0d, want err=0 lat=1", w, e, l);
      end
    end
  endtask

  task automatic test_word_rw();
    logic e; logic [31:0] r; int l;
    issue(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, e, r, l);
    checks++;
    if (e !== 1'b0 || r !== 32'h0 || l !== 1) begin
      failures++;
      $display("FAIL word_store err=%0b rdata=%h lat=%0d, want 0 00000000 1", e, r, l);
    end
    issue(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, e, r, l);
    checks++;
    if (e !== 1'b0 || r !== 32'hDEADBEEF || l !== 2) begin
      failures++;
      $display("FAIL word_load err=%0b rdata=%h lat=%0d, want 0 deadbeef 2", e, r, l);
    end
  endtask

  task automatic test_byte_ext();
    logic e; logic [31:0] r; int l;
    issue(1'b1, 2'd0, 1'b0, 32'h13, 32'h0000_0080, e, r, l);
    checks++;
    if (e !== 1'b0 || l !== 1) begin
      failures++;
      $display("FAIL byte_store err=%0b lat=%0d, want 0 1", e, l);
    end
    issue(1'b0, 2'd0, 1'b0, 32'h13, 32'h0, e, r, l);
    checks++;
    if (e !== 1'b0 || r !== 32'hFFFF_FF80 || l !== 2) begin
      failures++;
      $display("FAIL byte_signed err=%0b rdata=%h lat=%0d, want 0 ffffff80 2", e, r, l);
    end
    issue(1'b0, 2'd0, 1'b1, 32'h13, 32'h0, e, r, l);
    checks++;
    if (r !== 32'h0000_0080) begin
      failures++;
      $display("FAIL byte_unsigned rdata=%h, want 00000080", r);
    end
    issue(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, e, r, l);
    checks++;
    if (r !== 32'h80AD_BEEF) begin
      failures++;
      $display("FAIL byte_merge rdata=%h, want 80adbeef", r);
    end
  endtask

  task automatic test_errors();
    logic e; logic [31:0] r; int l;
    issue(1'b0, 2'd1, 1'b0, 32'h11, 32'h0, e, r, l);
    checks++;
    if (e !== 1'b1 || r !== 32'h0 || l !== 1) begin
      failures++;
      $display("FAIL half_misalign err=%0b rdata=%h lat=%0d, want 1 00000000 1", e, r, l);
    end
    issue(1'b1, 2'd2, 1'b0, 32'h12, 32'h1234_5678, e, r, l);
    checks++;
    if (e !== 1'b1 || l !== 1) begin
      failures++;
      $display("FAIL word_misalign err=%0b lat=%0d, want 1 1", e, l);
    end
    issue(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, e, r, l);
    checks++;
    if (r !== 32'h80AD_BEEF) begin
      failures++;
      $display("FAIL misalign_no_write rdata=%h, want 80adbeef", r);
    end
    issue(1'b1, 2'd3, 1'b0, 32'h10, 32'h0, e, r, l);
    checks++;
    if (e !== 1'b1) begin
      failures++;
      $display("FAIL size3 err=%0b, want 1", e);
    end
    issue(1'b0, 2'd2, 1'b0, 32'(DEPTH*4 + 4), 32'h0, e, r, l);
    checks++;
    if (e !== 1'b1 || r !== 32'h0) begin
      failures++;
      $display("FAIL out_of_range err=%0b rdata=%h, want 1 00000000", e, r);
    end
  endtask

  task automatic test_mmio();
    logic e; logic [31:0] r; int l;
`ifdef MEM_MMIO_EN
    issue(1'b1, 2'd2, 1'b0, 32'h1000, 32'h0001_A5A5, e, r, l);
    checks++;
    if (e !== 1'b0 || led !== 16'hA5A5) begin
      failures++;
      $display("FAIL mmio_word err=%0b led=%h, want 0 a5a5", e, led);
    end
    issue(1'b1, 2'd0, 1'b0, 32'h1001, 32'h0000_003C, e, r, l);
    checks++;
    if (e !== 1'b0 || led !== 16'h3CA5) begin
      failures++;
      $display("FAIL mmio_byte err=%0b led=%h, want 0 3ca5", e, led);
    end
    issue(1'b0, 2'd1, 1'b0, 32'h1000, 32'h0, e, r, l);
    checks++;
    if (e !== 1'b0 || r !== 32'h0000_3CA5 || l !== 2) begin
      failures++;
      $display("FAIL mmio_load err=%0b rdata=%h lat=%0d, want 0 00003ca5 2", e, r, l);
    end
`else
    issue(1'b0, 2'd2, 1'b0, 32'h1000, 32'h0, e, r, l);
    checks++;
    if (e !== 1'b1 || l !== 1) begin
      failures++;
      $display("FAIL depth_edge_load err=%0b lat=%0d, want 1 1", e, l);
    end
    issue(1'b1, 2'd2, 1'b0, 32'h1000, 32'h0001_A5A5, e, r, l);
    checks++;
    if (e !== 1'b1 || led !== '0) begin
      failures++;
      $display("FAIL mmio_off_store err=%0b led=%h, want 1 0000", e, led);
    end
`endif
  endtask

  task automatic test_back_to_back();
    logic        me; logic [31:0] mr; int ml;
    logic [31:0] v;
    logic [7:0]  st_rsp, st_rdy;
    logic [8:0]  ld_rsp, ld_rdy;
    v = $urandom;
    model(1'b1, 2'd2, 1'b0, 32'h40, v, me, mr, ml);
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_size = 2'd2;
    bus.req_unsigned = 1'b0; bus.req_addr = 32'h40; bus.req_wdata = v;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      @(negedge clk);
      st_rsp[i] = bus.rsp_valid;
      st_rdy[i] = bus.req_ready;
    end
    bus.req_we = 1'b0;
    for (int i = 0; i < 9; i++) begin
      @(posedge clk);
      @(negedge clk);
      ld_rsp[i] = bus.rsp_valid;
      ld_rdy[i] = bus.req_ready;
      if (bus.rsp_valid) begin
        checks++;
        if (bus.rsp_rdata !== v || bus.rsp_err !== 1'b0) begin
          failures++;
          $display("FAIL b2b_load_data i=%0d rdata=%h err=%0b, want %h 0", i, bus.rsp_rdata, bus.rsp_err, v);
        end
      end
    end
    bus.req_valid = 1'b0;
    checks++;
    if (st_rsp !== 8'hAA || st_rdy !== 8'hAA) begin
      failures++;
      $display("FAIL b2b_store rsp=%b ready=%b, want 10101010 10101010", st_rsp, st_rdy);
    end
    checks++;
    if (ld_rsp !== 9'h124 || ld_rdy !== 9'h124) begin
      failures++;
      $display("FAIL b2b_load rsp=%b ready=%b, want 100100100 100100100", ld_rsp, ld_rdy);
    end
  endtask

  task automatic test_reset_mid();
    logic e; logic [31:0] r; int l;
    issue(1'b1, 2'd2, 1'b0, 32'h20, 32'h5555_5555, e, r, l);
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_size = 2'd2;
    bus.req_unsigned = 1'b0; bus.req_addr = 32'h20; bus.req_wdata = 32'h1111_1111;
    @(posedge clk);
    #1;
    rst = 1'b1;
    bus.req_valid = 1'b0;
    #1;
    checks++;
    if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_async ready=%0b valid=%0b, want 1 0", bus.req_ready, bus.rsp_valid);
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < LED_W/8; i++) led_m[i] = 8'h00;
    @(negedge clk);
    checks++;
    if (bus.rsp_valid !== 1'b0 || led !== '0 || bus.req_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_after valid=%0b led=%h ready=%0b, want 0 0000 1", bus.rsp_valid, led, bus.req_ready);
    end
    issue(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, e, r, l);
    checks++;
    if (e !== 1'b0 || r !== 32'h5555_5555) begin
      failures++;
      $display("FAIL reset_dropped_store err=%0b rdata=%h, want 0 55555555", e, r);
    end
  endtask

  task automatic test_random();
    logic        we, uns, e, me;
    logic [1:0]  sz;
    logic [31:0] addr, wd, r, mr;
    int          l, ml, sel;
    for (int n = 0; n < 400; n++) begin
      we  = 1'($urandom_range(0, 1));
      uns = 1'($urandom_range(0, 1));
      sz  = 2'($urandom_range(0, 3));
      wd  = $urandom;
      sel = $urandom_range(0, 9);
      if (sel < 7)       addr = 32'($urandom_range(0, 255));
      else if (sel == 7) addr = 32'(DEPTH*4 + $urandom_range(0, 4095));
      else if (sel == 8) addr = MMIO_BASE + 32'($urandom_range(0, 3));
      else               addr = $urandom | 32'h8000_0000;
      model(we, sz, uns, addr, wd, me, mr, ml);
      do_req(we, sz, uns, addr, wd, e, r, l);
      checks++;
      if (e !== me || r !== mr || l !== ml) begin
        failures++;
        $display("FAIL rand n=%0d we=%0b sz=%0d uns=%0b addr=%h err=%0b rdata=%h lat=%0d, want %0b %h %0d",
                 n, we, sz, uns, addr, e, r, l, me, mr, ml);
      end
      checks++;
      if (led !== led_exp()) begin
        failures++;
        $display("FAIL rand_led n=%0d led=%h, want %h", n, led, led_exp());
      end
    end
  endtask

  initial begin
    test_reset();
    test_init();
    test_word_rw();
    test_byte_ext();
    test_errors();
    test_mmio();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end
endmodule
